mem_access_unit: RTL

- Load/store front end placed directly upstream of the 128 kB word-organised data memory in the MIPS datapath.
- Turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests from the MEM stage into word reads/writes on the memory's address/write-data/memwrite/memread port.
- The memory has no byte enables, so sub-word stores are done by read-modify-write.
- Stalls the pipeline through req_ready and returns aligned, extended load data with a one-cycle response pulse.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_access_unit_load_align.sv | 39 +++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared size codes, FSM states and latencies for mem_access_unit
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LD_LAT  = 3;
  localparam int SW_LAT  = 2;
  localparam int RMW_LAT = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_ISSUE  = 3'd1,
    LD_DATA   = 3'd2,
    ST_WR     = 3'd3,
    RMW_RD    = 3'd4,
    RMW_MERGE = 3'd5,
    RMW_WR    = 3'd6,
    RESP      = 3'd7
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'b11) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - byte/half extract+extend for loads and merge for sub-word stores
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    rdata    = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        rdata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        rdata = {{16{sign_ext & half_sel[15]}}, half_sel};
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: begin
        rdata  = word;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-addressed load/store front end for a word-only data memory
// MEM_ACCESS_RMW_EN enables read-modify-write sub-word stores; otherwise they return an error.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int WORD_AW = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [WORD_AW-1:0] mem_dira,
  output logic [31:0]        mem_write_data,
  output logic               mem_memwrite,
  output logic               mem_memread,
  input  logic [31:0]        mem_out
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [31:0]       wr_data_q;
  logic              req_err;
  logic [31:0]       align_rdata;
  logic [31:0]       align_merged;

`ifdef MEM_ACCESS_RMW_EN
  assign req_err = misaligned(req_size, req_addr[1:0]);
`else
  // Without byte enables there is no way to do a sub-word store in one write.
  assign req_err = misaligned(req_size, req_addr[1:0]) ||
                   (req_write && (req_size != SZ_WORD));
  logic unused_merged;
  assign unused_merged = ^align_merged;
`endif

  load_align u_load_align (
    .word     (mem_out),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (signed_q),
    .wdata    (wr_data_q),
    .rdata    (align_rdata),
    .merged   (align_merged)
  );

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign mem_memread    = (state == LD_ISSUE) || (state == RMW_RD);
  assign mem_memwrite   = (state == ST_WR) || (state == RMW_WR);
  assign mem_dira       = addr_q[ADDR_W-1:2];
  assign mem_write_data = wr_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      wr_data_q  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            size_q    <= req_size;
            signed_q  <= req_signed;
            wr_data_q <= req_wdata;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (!req_write) begin
              state <= LD_ISSUE;
            end else if (req_size == SZ_WORD) begin
              state <= ST_WR;
            end
`ifdef MEM_ACCESS_RMW_EN
            else begin
              state <= RMW_RD;
            end
`endif
          end
        end
        LD_ISSUE: state <= LD_DATA;
        LD_DATA: begin
          resp_rdata <= align_rdata;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        ST_WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
`ifdef MEM_ACCESS_RMW_EN
        RMW_RD: state <= RMW_MERGE;
        // The merge overwrites the write-data register so RMW_WR drives it unchanged.
        RMW_MERGE: begin
          wr_data_q <= align_merged;
          state     <= RMW_WR;
        end
        RMW_WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
